// File: rtl/ircam_pkg.sv
// Shared types and default constants for the thermal-camera frame normaliser.
package ircam_pkg;

    // Byte-stream parser states
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SKIP   = 2'd1,
        PIX_LO = 2'd2,
        PIX_HI = 2'd3
    } ircam_state_e;

    // How the scaler result is produced for a pixel
    typedef enum logic [1:0] {
        SEL_DIV  = 2'd0,
        SEL_ZERO = 2'd1,
        SEL_FULL = 2'd2
    } ircam_sel_e;

    localparam int         DEF_FLOOR    = 2700;
    localparam int         DEF_CEIL_MIN = 3300;
    localparam int         DEF_CLIP_MAX = 3900;
    localparam logic [7:0] DEF_HDR_BYTE = 8'h5A;

endpackage

// File: rtl/ircam_frame_norm_if.sv
// Byte stream in, normalised pixel stream and frame markers out.
interface ircam_frame_norm_if #(
    parameter int PIX_W   = 16,
    parameter int OUT_W   = 8,
    parameter int NUM_PIX = 768
);
    localparam int IDX_W = $clog2(NUM_PIX);

    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             pix_valid;
    logic [OUT_W-1:0] pix_data;
    logic [IDX_W-1:0] pix_index;
    logic             frame_start;
    logic             frame_done;
    logic             frame_err;
    logic [PIX_W-1:0] frame_max;

    // Byte source / pixel sink side
    modport master (
        output byte_valid, byte_data,
        input  pix_valid, pix_data, pix_index, frame_start, frame_done, frame_err, frame_max
    );

    // Normaliser side
    modport slave (
        input  byte_valid, byte_data,
        output pix_valid, pix_data, pix_index, frame_start, frame_done, frame_err, frame_max
    );
endinterface

// File: rtl/ircam_div.sv
// Restoring divider producing a Q_W-bit quotient in Q_W cycles.
// Caller guarantees num[NUM_W-1:Q_W] < den so the quotient fits.
module ircam_div
    import ircam_pkg::*;
#(
    parameter int NUM_W = 24,
    parameter int DEN_W = 16,
    parameter int Q_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [Q_W-1:0]   quo
);
    localparam int CNT_W = $clog2(Q_W + 1);

    logic [DEN_W-1:0] rem_q, rem_d, den_q, den_d;
    logic [Q_W-1:0]   sh_q, sh_d, quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [DEN_W:0]   trial, trial_sub;
    logic             fits;

    // Load on start, then one shift/subtract step per cycle
    always_comb begin
        trial     = {rem_q, sh_q[Q_W-1]};
        trial_sub = trial - {1'b0, den_q};
        fits      = trial >= {1'b0, den_q};
        rem_d     = rem_q;
        den_d     = den_q;
        sh_d      = sh_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        if (start && cnt_q == '0) begin
            rem_d = num[NUM_W-1:Q_W];
            sh_d  = num[Q_W-1:0];
            den_d = den;
            quo_d = '0;
            cnt_d = CNT_W'(Q_W);
        end else if (cnt_q != '0) begin
            rem_d  = fits ? trial_sub[DEN_W-1:0] : trial[DEN_W-1:0];
            sh_d   = sh_q << 1;
            quo_d  = (quo_q << 1) | Q_W'(fits);
            cnt_d  = cnt_q - 1'b1;
            done_d = (cnt_q == CNT_W'(1));
        end
    end

    // Divider state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            den_q  <= '0;
            sh_q   <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            den_q  <= den_d;
            sh_q   <= sh_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign busy = (cnt_q != '0);
    assign done = done_q;
    assign quo  = quo_q;

endmodule

// File: rtl/ircam_frame_norm.sv
// Frame decoder: header hunt, little-endian pixel assembly, hot-spot tracking
// and scaling of each pixel into an OUT_W-bit greyscale value.
module ircam_frame_norm
    import ircam_pkg::*;
#(
    parameter int         NUM_PIX    = 768,
    parameter int         PIX_W      = 16,
    parameter int         OUT_W      = 8,
    parameter logic [7:0] HDR_BYTE   = DEF_HDR_BYTE,
    parameter int         SKIP_BYTES = 2,
    parameter int         FLOOR      = DEF_FLOOR,
    parameter int         CEIL_MIN   = DEF_CEIL_MIN,
    parameter int         CLIP_MAX   = DEF_CLIP_MAX,
    parameter int         AUTO_RANGE = 1
) (
    input  logic                clk,
    input  logic                rst,
    ircam_frame_norm_if.slave   bus
);
    localparam int IDX_W  = $clog2(NUM_PIX);
    localparam int NUM_W  = PIX_W + OUT_W;
    localparam int SKIP_W = $clog2(SKIP_BYTES + 2);

    localparam logic [PIX_W-1:0] FLOOR_V = PIX_W'(FLOOR);
    localparam logic [PIX_W-1:0] CEIL_V  = PIX_W'(CEIL_MIN);
    localparam logic [PIX_W-1:0] CLIP_V  = PIX_W'(CLIP_MAX);

    ircam_state_e     state_q, state_d;
    logic [7:0]       prev_q, prev_d, lo_q, lo_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [PIX_W-1:0] run_max_q, run_max_d, frame_max_q, frame_max_d, hi_q, hi_d;
    ircam_sel_e       m_sel_q, m_sel_d;
    logic [IDX_W-1:0] m_idx_q, m_idx_d;
    logic             m_last_q, m_last_d;
    logic             pix_valid_q, pix_valid_d;
    logic [OUT_W-1:0] pix_data_q, pix_data_d;
    logic [IDX_W-1:0] pix_index_q, pix_index_d;
    logic             frame_start_q, frame_start_d;
    logic             last_out_q, last_out_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_err_q, frame_err_d;

    logic [15:0]      pix16;
    logic [PIX_W-1:0] pix_raw, diff, run_max_nxt;
    logic             hdr, pix_done, is_last;
    ircam_sel_e       pix_sel;
    logic [NUM_W-1:0] div_num;
    logic [PIX_W-1:0] div_den;
    logic             div_start, div_busy, div_done;
    logic [OUT_W-1:0] div_quo;

    // Pixel assembly, clamp decision and divider operands
    always_comb begin
        pix16       = {bus.byte_data, lo_q};
        pix_raw     = pix16[PIX_W-1:0];
        hdr         = bus.byte_valid && prev_q == HDR_BYTE && bus.byte_data == HDR_BYTE;
        pix_done    = bus.byte_valid && !hdr && state_q == PIX_HI;
        is_last     = (cnt_q == IDX_W'(NUM_PIX - 1));
        run_max_nxt = (pix_raw > run_max_q && pix_raw < CLIP_V) ? pix_raw : run_max_q;
        if (pix_raw <= FLOOR_V)  pix_sel = SEL_ZERO;
        else if (pix_raw >= hi_q) pix_sel = SEL_FULL;
        else                      pix_sel = SEL_DIV;
        // (p - FLOOR) * (2^OUT_W - 1) as a shift and subtract
        diff      = pix_raw - FLOOR_V;
        div_num   = {diff, {OUT_W{1'b0}}} - NUM_W'(diff);
        div_den   = hi_q - FLOOR_V;
        div_start = pix_done && !div_busy;
    end

    // Parser FSM, hot-spot tracking and range update
    always_comb begin
        state_d     = state_q;
        prev_d      = bus.byte_valid ? bus.byte_data : prev_q;
        lo_d        = lo_q;
        skip_d      = skip_q;
        cnt_d       = cnt_q;
        run_max_d   = run_max_q;
        frame_max_d = frame_max_q;
        hi_d        = hi_q;
        m_sel_d     = m_sel_q;
        m_idx_d     = m_idx_q;
        m_last_d    = m_last_q;
        frame_err_d = 1'b0;
        if (hdr) begin
            // Restart; a frame cut short leaves range and frame_max alone
            frame_err_d = (state_q == PIX_LO || state_q == PIX_HI);
            run_max_d   = '0;
            cnt_d       = '0;
            skip_d      = '0;
            state_d     = (SKIP_BYTES == 0) ? PIX_LO : SKIP;
        end else if (bus.byte_valid) begin
            case (state_q)
                SKIP: begin
                    if (skip_q == SKIP_W'(SKIP_BYTES - 1)) state_d = PIX_LO;
                    else                                    skip_d  = skip_q + 1'b1;
                end
                PIX_LO: begin
                    lo_d    = bus.byte_data;
                    state_d = PIX_HI;
                end
                PIX_HI: begin
                    run_max_d = run_max_nxt;
                    cnt_d     = cnt_q + 1'b1;
                    state_d   = PIX_LO;
                    // A busy scaler drops the pixel but the index still moves on
                    if (!div_busy) begin
                        m_sel_d  = pix_sel;
                        m_idx_d  = cnt_q;
                        m_last_d = is_last;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    if (is_last) begin
                        frame_max_d = run_max_nxt;
                        if (AUTO_RANGE != 0)
                            hi_d = (run_max_nxt > CEIL_V) ? run_max_nxt : CEIL_V;
                        cnt_d   = '0;
                        state_d = HUNT;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output stage: divided or clamped value, aligned to the divider result
    always_comb begin
        pix_valid_d   = div_done;
        pix_index_d   = m_idx_q;
        frame_start_d = div_done && m_idx_q == '0;
        last_out_d    = div_done && m_last_q;
        frame_done_d  = pix_valid_q && last_out_q;
        if (m_sel_q == SEL_ZERO)      pix_data_d = '0;
        else if (m_sel_q == SEL_FULL) pix_data_d = '1;
        else                          pix_data_d = div_quo;
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HUNT;
            prev_q        <= 8'h00;
            lo_q          <= '0;
            skip_q        <= '0;
            cnt_q         <= '0;
            run_max_q     <= '0;
            frame_max_q   <= '0;
            hi_q          <= CEIL_V;
            m_sel_q       <= SEL_DIV;
            m_idx_q       <= '0;
            m_last_q      <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_data_q    <= '0;
            pix_index_q   <= '0;
            frame_start_q <= 1'b0;
            last_out_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            lo_q          <= lo_d;
            skip_q        <= skip_d;
            cnt_q         <= cnt_d;
            run_max_q     <= run_max_d;
            frame_max_q   <= frame_max_d;
            hi_q          <= hi_d;
            m_sel_q       <= m_sel_d;
            m_idx_q       <= m_idx_d;
            m_last_q      <= m_last_d;
            pix_valid_q   <= pix_valid_d;
            pix_data_q    <= pix_data_d;
            pix_index_q   <= pix_index_d;
            frame_start_q <= frame_start_d;
            last_out_q    <= last_out_d;
            frame_done_q  <= frame_done_d;
            frame_err_q   <= frame_err_d;
        end
    end

    ircam_div #(
        .NUM_W (NUM_W),
        .DEN_W (PIX_W),
        .Q_W   (OUT_W)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .num   (div_num),
        .den   (div_den),
        .busy  (div_busy),
        .done  (div_done),
        .quo   (div_quo)
    );

    assign bus.pix_valid   = pix_valid_q;
    assign bus.pix_data    = pix_data_q;
    assign bus.pix_index   = pix_index_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.frame_max   = frame_max_q;

endmodule
